// File: rtl/pipelined_adder.sv
// pipelined_adder: ripple-carry adder/subtractor, one SEG-bit segment per pipeline stage.
// Operands skew forward a segment per stage; finished sum segments shift in from the top.
module pipelined_adder #(
    parameter int WIDTH = 8,
    parameter int SEG = 4,
    localparam int NSEG = WIDTH / SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    if (WIDTH % SEG != 0 || NSEG < 1) begin : g_bad_width
        $error("pipelined_adder: WIDTH must be a non-zero multiple of SEG");
    end
    logic [WIDTH-1:0] in_a [NSEG];
    logic [WIDTH-1:0] in_b [NSEG];
    logic [WIDTH-1:0] in_s [NSEG];
    logic [WIDTH-1:0] st_s [NSEG];
    logic [WIDTH-1:0] q_a [NSEG];
    logic [WIDTH-1:0] q_b [NSEG];
    logic [WIDTH-1:0] q_s [NSEG];
    logic [SEG-1:0]   st_seg [NSEG];
    logic             in_c [NSEG];
    logic             in_v [NSEG];
    logic             st_c [NSEG];
    logic             q_c [NSEG];
    logic             q_v [NSEG];
    logic             q_o;
    logic             ovf_n;
    // Operands are pre-shifted so each stage always works on the low SEG bits.
    always_comb begin
        in_a[0] = a;
        in_b[0] = sub ? ~b : b;
        in_s[0] = '0;
        in_c[0] = sub ^ cin;
        in_v[0] = in_valid;
        for (int k = 1; k < NSEG; k++) begin
            in_a[k] = q_a[k-1];
            in_b[k] = q_b[k-1];
            in_s[k] = q_s[k-1];
            in_c[k] = q_c[k-1];
            in_v[k] = q_v[k-1];
        end
        for (int k = 0; k < NSEG; k++) begin
            {st_c[k], st_seg[k]} = {1'b0, in_a[k][SEG-1:0]} + {1'b0, in_b[k][SEG-1:0]} + (SEG+1)'(in_c[k]);
            st_s[k] = (in_s[k] >> SEG) | (WIDTH'(st_seg[k]) << (WIDTH - SEG));
        end
        // Carry into the MSB is recovered from the MSB operand and sum bits.
        ovf_n = in_a[NSEG-1][SEG-1] ^ in_b[NSEG-1][SEG-1] ^ st_seg[NSEG-1][SEG-1] ^ st_c[NSEG-1];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSEG; k++) begin
                q_a[k] <= '0;
                q_b[k] <= '0;
                q_s[k] <= '0;
                q_c[k] <= 1'b0;
                q_v[k] <= 1'b0;
            end
            q_o <= 1'b0;
        end else begin
            for (int k = 0; k < NSEG; k++) begin
                q_v[k] <= in_v[k];
                if (in_v[k]) begin
                    q_a[k] <= in_a[k] >> SEG;
                    q_b[k] <= in_b[k] >> SEG;
                    q_s[k] <= st_s[k];
                    q_c[k] <= st_c[k];
                end
            end
            if (in_v[NSEG-1]) q_o <= ovf_n;
        end
    end
    assign out_valid = q_v[NSEG-1];
    assign sum = q_s[NSEG-1];
    assign cout = q_c[NSEG-1];
    assign ovf = q_o;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed vector table plus streaming and reset corner sequences.
module tb_pipelined_adder;
    logic clk, rst, in_valid, cin, sub;
    logic [7:0] a, b;
    logic out_valid, cout, ovf;
    logic [7:0] sum;
    int total = 0;
    int bad = 0;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;
    vec_t vecs [11];
    pipelined_adder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .sum(sum), .cout(cout), .ovf(ovf)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask
    task automatic drive(input logic v, input logic [7:0] xa, input logic [7:0] xb, input logic c, input logic s);
        in_valid = v;
        a = xa;
        b = xb;
        cin = c;
        sub = s;
    endtask
    initial begin
        vecs[0]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[6]  = '{8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[7]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[8]  = '{8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[9]  = '{8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[10] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset out_valid", {8'h0, out_valid}, 9'h0);
        chk("reset sum", {1'b0, sum}, 9'h0);
        chk("reset cout", {8'h0, cout}, 9'h0);
        chk("reset ovf", {8'h0, ovf}, 9'h0);
        repeat (3) begin
            @(negedge clk);
            chk("idle out_valid", {8'h0, out_valid}, 9'h0);
        end
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            @(negedge clk);
            drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            chk($sformatf("vec%0d early valid", i), {8'h0, out_valid}, 9'h0);
            @(negedge clk);
            chk($sformatf("vec%0d valid", i), {8'h0, out_valid}, 9'h1);
            chk($sformatf("vec%0d sum", i), {1'b0, sum}, {1'b0, vecs[i].s});
            chk($sformatf("vec%0d cout", i), {8'h0, cout}, {8'h0, vecs[i].co});
            chk($sformatf("vec%0d ovf", i), {8'h0, ovf}, {8'h0, vecs[i].ov});
            @(negedge clk);
            chk($sformatf("vec%0d one-cycle valid", i), {8'h0, out_valid}, 9'h0);
            chk($sformatf("vec%0d hold sum", i), {1'b0, sum}, {1'b0, vecs[i].s});
        end
        drive(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        chk("stream c0 valid", {8'h0, out_valid}, 9'h0);
        drive(1'b1, 8'h10, 8'h10, 1'b0, 1'b0);
        @(negedge clk);
        chk("stream c1 valid", {8'h0, out_valid}, 9'h1);
        chk("stream c1 sum", {1'b0, sum}, 9'h02);
        drive(1'b0, 8'hEE, 8'hEE, 1'b1, 1'b1);
        @(negedge clk);
        chk("stream c2 valid", {8'h0, out_valid}, 9'h1);
        chk("stream c2 sum", {1'b0, sum}, 9'h20);
        drive(1'b1, 8'h20, 8'h01, 1'b0, 1'b1);
        @(negedge clk);
        chk("stream bubble valid", {8'h0, out_valid}, 9'h0);
        chk("stream bubble hold", {1'b0, sum}, 9'h20);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("stream c4 valid", {8'h0, out_valid}, 9'h1);
        chk("stream c4 sum", {1'b0, sum}, 9'h1F);
        chk("stream c4 cout", {8'h0, cout}, 9'h1);
        @(negedge clk);
        drive(1'b1, 8'h33, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 8'h44, 8'h44, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("midreset valid", {8'h0, out_valid}, 9'h0);
        chk("midreset sum", {1'b0, sum}, 9'h0);
        drive(1'b1, 8'h02, 8'h03, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("reset-cycle op dropped", {8'h0, out_valid}, 9'h0);
        @(negedge clk);
        chk("post-reset valid", {8'h0, out_valid}, 9'h1);
        chk("post-reset sum", {1'b0, sum}, 9'h05);
        @(negedge clk);
        chk("post-reset drain", {8'h0, out_valid}, 9'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
